// File: rtl/spi_responder.sv
// spi_responder: SPI mode-0 target with byte handshake to the register file.
// Pins are synchronised into raw_clk; all actions occur three cycles after a pin edge.
module spi_responder #(
  parameter logic [7:0] IDLE_FILL = 8'hff
) (
  input  logic       raw_clk,
  input  logic       reset_n,
  input  logic       sclk,
  input  logic       mosi,
  input  logic       cs_n,
  output logic       miso,
  output logic       miso_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_load,
  output logic       tx_busy,
  output logic [7:0] rx_data,
  output logic       rx_ready,
  input  logic       rx_ready_clear,
  output logic       overrun,
  input  logic       overrun_clear
);
  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t state, state_next;
  logic [2:0] sclk_s, cs_s;
  logic [1:0] mosi_s;
  logic [2:0] bit_count;
  logic [7:0] tx_shift, rx_shift, holding;
  logic start, stop, rise, fall, consume, byte_done;
  always_comb begin
    start = (state == IDLE) && !cs_s[1] && cs_s[2];
    stop = (state == ACTIVE) && cs_s[1] && !cs_s[2];
    // sclk edges are only honoured while selected and not being deselected
    rise = (state == ACTIVE) && !stop && sclk_s[1] && !sclk_s[2];
    fall = (state == ACTIVE) && !stop && !sclk_s[1] && sclk_s[2];
    consume = start || (fall && bit_count == 3'd0);
    byte_done = rise && bit_count == 3'd7;
    state_next = start ? ACTIVE : stop ? IDLE : state;
  end
  always_ff @(posedge raw_clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else state <= state_next;
  end
  always_ff @(posedge raw_clk or negedge reset_n) begin
    if (!reset_n) begin
      sclk_s <= 3'b000;
      cs_s <= 3'b111;
      mosi_s <= 2'b00;
      bit_count <= 3'd0;
      tx_shift <= 8'd0;
      rx_shift <= 8'd0;
      holding <= 8'd0;
      miso_oe <= 1'b0;
      tx_busy <= 1'b0;
      rx_data <= 8'd0;
      rx_ready <= 1'b0;
      overrun <= 1'b0;
    end else begin
      sclk_s <= {sclk_s[1:0], sclk};
      cs_s <= {cs_s[1:0], cs_n};
      mosi_s <= {mosi_s[0], mosi};
      if (start || stop) begin
        bit_count <= 3'd0;
        miso_oe <= start;
      end else if (rise) begin
        bit_count <= bit_count + 3'd1;
        rx_shift <= {rx_shift[6:0], mosi_s[1]};
      end
      if (consume) tx_shift <= tx_busy ? holding : IDLE_FILL;
      else if (fall) tx_shift <= {tx_shift[6:0], 1'b0};
      // a load in the same cycle as a consume leaves the new byte pending
      if (tx_load) begin
        holding <= tx_data;
        tx_busy <= 1'b1;
      end else if (consume) tx_busy <= 1'b0;
      if (byte_done) rx_data <= {rx_shift[6:0], mosi_s[1]};
      rx_ready <= byte_done || (rx_ready && !rx_ready_clear);
      overrun <= (byte_done && rx_ready && !rx_ready_clear) || (overrun && !overrun_clear);
    end
  end
  assign miso = tx_shift[7];
endmodule

// File: tb/tb_spi_responder.sv
// tb_spi_responder: mode-0 master model with queue scoreboard for MISO and RX bytes.
module tb_spi_responder;
  logic raw_clk = 1'b0;
  logic reset_n = 1'b0;
  logic sclk = 1'b0, mosi = 1'b0, cs_n = 1'b1;
  logic miso, miso_oe, tx_busy, rx_ready, overrun;
  logic [7:0] tx_data = 8'd0, rx_data;
  logic tx_load = 1'b0, rx_ready_clear = 1'b0, overrun_clear = 1'b0;
  int n_chk = 0, n_pass = 0;
  logic [7:0] rx_q[$], tx_q[$];

  spi_responder dut (
    .raw_clk(raw_clk), .reset_n(reset_n), .sclk(sclk), .mosi(mosi), .cs_n(cs_n),
    .miso(miso), .miso_oe(miso_oe), .tx_data(tx_data), .tx_load(tx_load),
    .tx_busy(tx_busy), .rx_data(rx_data), .rx_ready(rx_ready),
    .rx_ready_clear(rx_ready_clear), .overrun(overrun), .overrun_clear(overrun_clear)
  );

  always #5 raw_clk = ~raw_clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge raw_clk);
    #1;
  endtask

  task automatic load(input logic [7:0] d);
    tx_data = d;
    tx_load = 1'b1;
    tick(1);
    tx_load = 1'b0;
  endtask

  task automatic pulse_rx_clear();
    rx_ready_clear = 1'b1;
    tick(1);
    rx_ready_clear = 1'b0;
  endtask

  // optional tx_load lands exactly on the select-edge consume
  task automatic select_begin(input bit ld, input logic [7:0] d);
    cs_n = 1'b0;
    tick(2);
    tx_data = d;
    tx_load = ld;
    tick(1);
    tx_load = 1'b0;
    tick(1);
  endtask

  task automatic select_end();
    tick(4);
    cs_n = 1'b1;
    tick(6);
  endtask

  task automatic xfer(input logic [7:0] mo, input logic [7:0] exp_miso, input bit clr_last, input bit chk_lat);
    logic [7:0] got;
    rx_q.push_back(mo);
    tx_q.push_back(exp_miso);
    for (int i = 7; i >= 0; i--) begin
      mosi = mo[i];
      tick(4);
      got[i] = miso;
      sclk = 1'b1;
      tick(2);
      if (i == 0 && chk_lat) check("rx_ready_pre", rx_ready, 0);
      rx_ready_clear = clr_last && i == 0;
      tick(1);
      rx_ready_clear = 1'b0;
      if (i == 0 && chk_lat) check("rx_ready_lat3", rx_ready, 1);
      tick(1);
      sclk = 1'b0;
    end
    check("rx_data", rx_data, rx_q.pop_front());
    check("rx_ready", rx_ready, 1);
    check("miso_byte", got, tx_q.pop_front());
  endtask

  initial begin
    tick(1);
    check("rst_miso", miso, 0);
    check("rst_oe", miso_oe, 0);
    check("rst_busy", tx_busy, 0);
    check("rst_rx_data", rx_data, 0);
    check("rst_rx_ready", rx_ready, 0);
    check("rst_overrun", overrun, 0);
    reset_n = 1'b1;
    tick(4);
    check("idle_oe", miso_oe, 0);

    load(8'hA5);
    check("busy_after_load", tx_busy, 1);
    select_begin(0, 8'h00);
    check("oe_active", miso_oe, 1);
    check("busy_consumed", tx_busy, 0);
    xfer(8'h3C, 8'hA5, 0, 1);
    select_end();
    check("oe_released", miso_oe, 0);
    pulse_rx_clear();
    check("rx_cleared", rx_ready, 0);

    load(8'h11);
    select_begin(0, 8'h00);
    xfer(8'h5A, 8'h11, 1, 0);
    xfer(8'h96, 8'hFF, 1, 0);
    select_end();
    check("no_overrun_cleared", overrun, 0);
    pulse_rx_clear();

    select_begin(0, 8'h00);
    xfer(8'h01, 8'hFF, 0, 0);
    xfer(8'h02, 8'hFF, 0, 0);
    select_end();
    check("overrun_set", overrun, 1);
    overrun_clear = 1'b1;
    tick(1);
    overrun_clear = 1'b0;
    check("overrun_clr", overrun, 0);
    pulse_rx_clear();

    select_begin(0, 8'h00);
    for (int i = 0; i < 5; i++) begin
      mosi = i[0];
      tick(4);
      sclk = 1'b1;
      tick(4);
      sclk = 1'b0;
    end
    tick(4);
    cs_n = 1'b1;
    tick(8);
    check("abort_rx_ready", rx_ready, 0);
    check("abort_oe", miso_oe, 0);
    select_begin(0, 8'h00);
    xfer(8'hC3, 8'hFF, 0, 1);
    select_end();

    select_begin(0, 8'h00);
    xfer(8'h4E, 8'hFF, 1, 0);
    select_end();
    check("clr_collide_overrun", overrun, 0);

    load(8'h66);
    select_begin(1, 8'h77);
    check("collide_busy", tx_busy, 1);
    xfer(8'h12, 8'h66, 1, 0);
    xfer(8'h34, 8'h77, 1, 0);
    check("collide_busy_done", tx_busy, 0);
    select_end();

    load(8'hE7);
    select_begin(0, 8'h00);
    mosi = 1'b1;
    tick(4);
    sclk = 1'b1;
    tick(4);
    reset_n = 1'b0;
    cs_n = 1'b1;
    sclk = 1'b0;
    #1;
    check("mid_rst_oe", miso_oe, 0);
    check("mid_rst_ready", rx_ready, 0);
    check("mid_rst_data", rx_data, 0);
    check("mid_rst_busy", tx_busy, 0);
    check("mid_rst_miso", miso, 0);
    tick(2);
    reset_n = 1'b1;
    tick(6);
    check("post_rst_oe", miso_oe, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
